// File: rtl/output_collector_pkg.sv
// Shared types and sizing helpers for the output collector.
package output_collector_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   // Address is {y, x, ch}, so each coordinate gets its own clog2-wide field.
   function automatic int calc_addr_width(input int w, input int h, input int c);
      return $clog2(w) + $clog2(h) + $clog2(c);
   endfunction

   function automatic int calc_total(input int w, input int h, input int c);
      return w * h * c;
   endfunction

   function automatic int calc_count_width(input int w, input int h, input int c);
      return $clog2(calc_total(w, h, c) + 1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO; a push on a full FIFO is honoured only if a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_in,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW:0]      wr_ptr_q, wr_ptr_d;
   logic [PW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty_o    = (wr_ptr_q == rd_ptr_q);
   assign full_o     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign do_pop     = pop_i && !empty_o;
   assign do_push    = push_i && (!full_o || do_pop);
   assign pop_data_o = mem_q[rd_ptr_q[PW-1:0]];

   // Pointer advance for accepted pushes and pops.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
   end

   // Pointer registers; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: contents are only visible through valid pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/output_collector.sv
// Collects one output tensor per start into the result memory, buffering bursts behind a stalling write port.
//
// state   | meaning
// IDLE    | waiting for start; any sample is stray
// COLLECT | accepting samples until W*H*C have been seen (drops included)
// DRAIN   | frame count reached; emptying FIFO and write register
// DONE    | one-cycle completion pulse, then back to IDLE
module output_collector
   import output_collector_pkg::*;
#(
   parameter int IO_DATA_WIDTH      = 16,
   parameter int MEM_WIDTH          = 32,
   parameter int FEATURE_MAP_WIDTH  = 1024,
   parameter int FEATURE_MAP_HEIGHT = 1024,
   parameter int OUTPUT_NB_CHANNELS = 64,
   parameter int FIFO_DEPTH         = 4,
   parameter int ADDR_WIDTH         = calc_addr_width(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS)
) (
   input  logic                                      clk,
   input  logic                                      rst_in,
   input  logic                                      start,
   input  logic signed [IO_DATA_WIDTH-1:0]           out,
   input  logic                                      output_valid,
   input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]      output_x,
   input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]     output_y,
   input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]     output_ch,
   output logic [ADDR_WIDTH-1:0]                     mem_write_addr,
   output logic [MEM_WIDTH-1:0]                      mem_din,
   output logic                                      mem_write_en,
   input  logic                                      mem_write_ready,
   output logic                                      collecting,
   output logic                                      done,
   output logic                                      overflow,
   output logic                                      stray
);
   localparam int TOTAL   = calc_total(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS);
   localparam int CNT_W   = calc_count_width(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS);
   localparam int ENTRY_W = ADDR_WIDTH + IO_DATA_WIDTH;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   overflow_q, overflow_d;
   logic                   stray_q, stray_d;
   logic                   wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
   logic [MEM_WIDTH-1:0]   wr_data_q, wr_data_d;

   logic                   sample_in;
   logic [ENTRY_W-1:0]     in_entry, head_entry, load_entry;
   logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic                   reg_free, bypass, load, drop;

   assign sample_in  = output_valid && (state_q == ST_COLLECT);
   assign in_entry   = {ADDR_WIDTH'({output_y, output_x, output_ch}), out};

   // The write register takes a new word whenever it is empty or its word transfers this cycle.
   // With an empty FIFO the incoming sample skips the FIFO, giving one-cycle latency.
   assign reg_free   = !wr_en_q || mem_write_ready;
   assign fifo_pop   = reg_free && !fifo_empty;
   assign bypass     = reg_free && fifo_empty && sample_in;
   assign fifo_push  = sample_in && !bypass && (!fifo_full || fifo_pop);
   assign drop       = sample_in && !bypass && fifo_full && !fifo_pop;
   assign load       = fifo_pop || bypass;
   assign load_entry = fifo_empty ? in_entry : head_entry;

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_in      (rst_in),
      .push_i      (fifo_push),
      .push_data_i (in_entry),
      .pop_i       (fifo_pop),
      .pop_data_o  (head_entry),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Write port next-state: load, retire on transfer, otherwise hold stable.
   always_comb begin
      wr_en_d   = wr_en_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (load) begin
         wr_en_d   = 1'b1;
         wr_addr_d = load_entry[ENTRY_W-1 -: ADDR_WIDTH];
         wr_data_d = {{(MEM_WIDTH-IO_DATA_WIDTH){load_entry[IO_DATA_WIDTH-1]}},
                      load_entry[IO_DATA_WIDTH-1:0]};
      end else if (mem_write_ready) begin
         wr_en_d = 1'b0;
      end
   end

   // FSM next-state, frame counter and sticky error flags.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      stray_d    = stray_q;
      unique case (state_q)
         ST_IDLE: begin
            if (output_valid) stray_d = 1'b1;
            if (start) begin
               state_d    = ST_COLLECT;
               count_d    = '0;
               overflow_d = 1'b0;
               stray_d    = 1'b0;
            end
         end
         ST_COLLECT: begin
            if (drop) overflow_d = 1'b1;
            if (output_valid) begin
               count_d = count_q + CNT_W'(1);
               if (count_d == CNT_W'(TOTAL)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (output_valid) overflow_d = 1'b1;
            if (fifo_empty && reg_free) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (output_valid) stray_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and write-port registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         overflow_q <= 1'b0;
         stray_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         stray_q    <= stray_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign mem_write_en   = wr_en_q;
   assign mem_write_addr = wr_addr_q;
   assign mem_din        = wr_data_q;
   assign collecting     = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
   assign done           = (state_q == ST_DONE);
   assign overflow       = overflow_q;
   assign stray          = stray_q;

endmodule

// File: tb/tb_output_collector.sv
// Bench for output_collector on a 2x2x2 tensor with a 4-entry FIFO.
module tb_output_collector;
   localparam int W = 2, H = 2, C = 2, DEPTH = 4, IOW = 16, MW = 32, AW = 3;
   localparam int TOTAL = W * H * C;

   logic            clk = 1'b0;
   logic            rst_in, start, output_valid, mem_write_ready;
   logic [IOW-1:0]  out_s;
   logic [0:0]      output_x, output_y, output_ch;
   logic [AW-1:0]   mem_write_addr;
   logic [MW-1:0]   mem_din;
   logic            mem_write_en, collecting, done, overflow, stray;

   always #5 clk = ~clk;

   output_collector #(
      .IO_DATA_WIDTH      (IOW),
      .MEM_WIDTH          (MW),
      .FEATURE_MAP_WIDTH  (W),
      .FEATURE_MAP_HEIGHT (H),
      .OUTPUT_NB_CHANNELS (C),
      .FIFO_DEPTH         (DEPTH),
      .ADDR_WIDTH         (AW)
   ) dut (
      .clk             (clk),
      .rst_in          (rst_in),
      .start           (start),
      .out             (out_s),
      .output_valid    (output_valid),
      .output_x        (output_x),
      .output_y        (output_y),
      .output_ch       (output_ch),
      .mem_write_addr  (mem_write_addr),
      .mem_din         (mem_din),
      .mem_write_en    (mem_write_en),
      .mem_write_ready (mem_write_ready),
      .collecting      (collecting),
      .done            (done),
      .overflow        (overflow),
      .stray           (stray)
   );

   int checks = 0, errors = 0;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [MW-1:0] d;
   } wr_t;
   wr_t exp_q[$], act_q[$];

   // Reference model: frame phase, samples seen, words in flight (FIFO + write register).
   typedef enum {M_IDLE, M_COLLECT, M_DRAIN, M_DONE} mphase_t;
   mphase_t m_ph = M_IDLE;
   int      m_count = 0, m_inflight = 0;
   bit      m_ovf = 0, m_stray = 0;

   int            en_bad, done_bad, coll_bad, stall_viol, done_seen;
   bit            prev_stall = 0;
   logic [AW-1:0] prev_a;
   logic [MW-1:0] prev_d;

   // One cycle: observe outputs at the negedge, drive inputs, advance the model.
   task automatic step(input bit rst, input bit st, input bit v, input logic [15:0] d,
                       input int x, input int y, input int ch, input bit rdy);
      bit  xfer;
      wr_t e;
      if (mem_write_en !== (m_inflight > 0)) en_bad++;
      if (done !== (m_ph == M_DONE)) done_bad++;
      if (collecting !== (m_ph == M_COLLECT || m_ph == M_DRAIN)) coll_bad++;
      if (done === 1'b1) done_seen++;
      if (prev_stall && (mem_write_en !== 1'b1 || mem_write_addr !== prev_a || mem_din !== prev_d))
         stall_viol++;
      rst_in = rst; start = st; output_valid = v; out_s = d;
      output_x = 1'(x); output_y = 1'(y); output_ch = 1'(ch); mem_write_ready = rdy;
      if (mem_write_en === 1'b1 && rdy) act_q.push_back({mem_write_addr, mem_din});
      prev_stall = (mem_write_en === 1'b1) && !rdy && !rst;
      prev_a = mem_write_addr; prev_d = mem_din;

      xfer = (m_inflight > 0) && rdy;
      if (xfer) m_inflight--;
      if (rst) begin
         repeat (m_inflight) void'(exp_q.pop_back());
         m_inflight = 0; m_ph = M_IDLE; m_count = 0; m_ovf = 0; m_stray = 0;
      end else begin
         case (m_ph)
            M_IDLE: begin
               if (v) m_stray = 1;
               if (st) begin m_ph = M_COLLECT; m_count = 0; m_ovf = 0; m_stray = 0; end
            end
            M_COLLECT: if (v) begin
               m_count++;
               if (m_inflight == DEPTH + 1) m_ovf = 1;
               else begin
                  e.a = AW'(y * (W * C) + x * C + ch);
                  e.d = {{(MW-IOW){d[15]}}, d};
                  exp_q.push_back(e);
                  m_inflight++;
               end
               if (m_count == TOTAL) m_ph = M_DRAIN;
            end
            M_DRAIN: begin
               if (v) m_ovf = 1;
               if (m_inflight == 0) m_ph = M_DONE;
            end
            default: begin
               if (v) m_stray = 1;
               m_ph = M_IDLE;
            end
         endcase
      end
      @(negedge clk);
   endtask

   task automatic clear_obs();
      exp_q.delete(); act_q.delete();
      en_bad = 0; done_bad = 0; coll_bad = 0; stall_viol = 0; done_seen = 0;
   endtask

   function automatic int q_mismatch();
      int n = 0;
      if (exp_q.size() != act_q.size()) n++;
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
         if (exp_q[i] !== act_q[i]) n++;
      return n;
   endfunction

   // Feed random samples while collecting and drain until the model is back in IDLE.
   task automatic finish_frame(input int rdy_pct, output bit ok);
      ok = 0;
      for (int k = 0; k < 300; k++) begin
         if (m_ph == M_IDLE) begin ok = 1; break; end
         step(0, 0, (m_ph == M_COLLECT) ? 1'($urandom_range(0, 1)) : 1'b0, 16'($urandom),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 99) < rdy_pct);
      end
   endtask

   task automatic test_reset();
      clear_obs();
      repeat (3) step(1, 0, 1, 16'h1234, 1, 1, 1, 0);
      checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", mem_write_en); end
      checks++; if (mem_write_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_write_addr); end
      checks++; if (mem_din !== '0) begin errors++; $display("FAIL reset_din: got %h expected 0", mem_din); end
      checks++; if ({done, collecting} !== 2'b00) begin errors++; $display("FAIL reset_done_coll: got %b expected 00", {done, collecting}); end
      checks++; if ({overflow, stray} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {overflow, stray}); end
      step(0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic test_ordered_frame();
      bit ok;
      clear_obs();
      step(0, 1, 0, 0, 0, 0, 0, 1);
      checks++; if (collecting !== 1'b1) begin errors++; $display("FAIL start_collecting: got %b expected 1", collecting); end
      for (int i = 0; i < TOTAL; i++) step(0, 0, 1, 16'(i + 1), (i >> 1) & 1, (i >> 2) & 1, i & 1, 1);
      finish_frame(100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ordered_timeout: got 0 expected 1"); end
      checks++; if (act_q.size() !== TOTAL) begin errors++; $display("FAIL ordered_count: got %0d expected %0d", act_q.size(), TOTAL); end
      for (int i = 0; i < act_q.size(); i++) begin
         checks++;
         if (act_q[i].a !== AW'(i) || act_q[i].d !== MW'(i + 1)) begin
            errors++; $display("FAIL ordered_word%0d: got %h/%h expected %h/%h", i, act_q[i].a, act_q[i].d, AW'(i), MW'(i + 1));
         end
      end
      checks++; if (done_seen !== 1) begin errors++; $display("FAIL ordered_done_pulses: got %0d expected 1", done_seen); end
      checks++; if (en_bad + done_bad + coll_bad !== 0) begin errors++; $display("FAIL ordered_timing: got %0d/%0d/%0d bad cycles expected 0", en_bad, done_bad, coll_bad); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ordered_overflow: got %b expected 0", overflow); end
   endtask

   task automatic test_sign_ext();
      bit ok;
      clear_obs();
      step(0, 1, 0, 0, 0, 0, 0, 1);
      step(0, 0, 1, 16'h8001, 1, 0, 1, 1);
      checks++; if (mem_write_en !== 1'b1) begin errors++; $display("FAIL latency_en: got %b expected 1", mem_write_en); end
      checks++; if (mem_write_addr !== 3'd3) begin errors++; $display("FAIL sext_addr: got %h expected 3", mem_write_addr); end
      checks++; if (mem_din !== 32'hFFFF8001) begin errors++; $display("FAIL sext_din: got %h expected ffff8001", mem_din); end
      finish_frame(100, ok);
      checks++; if (!ok || q_mismatch() !== 0) begin errors++; $display("FAIL sext_frame: got ok=%0d mismatches=%0d expected 1/0", ok, q_mismatch()); end
   endtask

   task automatic test_stall();
      bit ok;
      clear_obs();
      step(0, 1, 0, 0, 0, 0, 0, 1);
      step(0, 0, 1, 16'h0011, 0, 0, 0, 1);
      step(0, 0, 1, 16'h0022, 1, 0, 0, 0);
      step(0, 0, 1, 16'h0033, 0, 1, 0, 0);
      step(0, 0, 1, 16'hF044, 1, 1, 1, 0);
      finish_frame(100, ok);
      checks++; if (stall_viol !== 0) begin errors++; $display("FAIL stall_hold: got %0d violations expected 0", stall_viol); end
      checks++; if (!ok || act_q.size() !== TOTAL || q_mismatch() !== 0) begin errors++; $display("FAIL stall_order: got %0d words, %0d mismatches expected %0d/0", act_q.size(), q_mismatch(), TOTAL); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stall_overflow: got %b expected 0", overflow); end
   endtask

   task automatic test_overflow();
      bit ok;
      clear_obs();
      step(0, 1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) step(0, 0, 1, 16'(16'h0100 + i), i & 1, (i >> 1) & 1, (i >> 2) & 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      finish_frame(100, ok);
      checks++; if (!ok || act_q.size() !== TOTAL - 1) begin errors++; $display("FAIL ovf_kept: got %0d words expected %0d", act_q.size(), TOTAL - 1); end
      checks++; if (q_mismatch() !== 0) begin errors++; $display("FAIL ovf_order: got %0d mismatches expected 0", q_mismatch()); end
      checks++; if (done_seen !== 1 || stall_viol !== 0) begin errors++; $display("FAIL ovf_done: got %0d pulses/%0d stalls expected 1/0", done_seen, stall_viol); end
   endtask

   task automatic test_stray();
      bit ok;
      clear_obs();
      step(0, 0, 1, 16'h0555, 1, 1, 0, 1);
      step(0, 0, 1, 16'h0666, 0, 1, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (stray !== 1'b1) begin errors++; $display("FAIL stray_flag: got %b expected 1", stray); end
      checks++; if (act_q.size() !== 0 || mem_write_en !== 1'b0) begin errors++; $display("FAIL stray_nowrite: got %0d words en=%b expected 0/0", act_q.size(), mem_write_en); end
      step(0, 1, 0, 0, 0, 0, 0, 1);
      checks++; if (stray !== 1'b0) begin errors++; $display("FAIL stray_clear: got %b expected 0", stray); end
      finish_frame(80, ok);
      checks++; if (!ok || q_mismatch() !== 0) begin errors++; $display("FAIL stray_frame: got ok=%0d mismatches=%0d expected 1/0", ok, q_mismatch()); end
   endtask

   task automatic test_random_frames();
      bit ok;
      clear_obs();
      for (int f = 0; f < 6; f++) begin
         step(0, 1, 0, 0, 0, 0, 0, 1);
         ok = 0;
         for (int k = 0; k < 400; k++) begin
            if (m_ph == M_IDLE) begin ok = 1; break; end
            step(0, $urandom_range(0, 15) == 0,
                 (m_ph == M_COLLECT) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0),
                 16'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 9) < 6);
         end
         checks++; if (!ok) begin errors++; $display("FAIL rand_timeout%0d: got 0 expected 1", f); end
         checks++; if ({overflow, stray} !== {m_ovf, m_stray}) begin errors++; $display("FAIL rand_flags%0d: got %b expected %b", f, {overflow, stray}, {m_ovf, m_stray}); end
      end
      checks++; if (q_mismatch() !== 0) begin errors++; $display("FAIL rand_words: got %0d mismatches expected 0", q_mismatch()); end
      checks++; if (done_seen !== 6) begin errors++; $display("FAIL rand_done_pulses: got %0d expected 6", done_seen); end
      checks++; if (en_bad + done_bad + coll_bad + stall_viol !== 0) begin errors++; $display("FAIL rand_timing: got %0d/%0d/%0d/%0d bad cycles expected 0", en_bad, done_bad, coll_bad, stall_viol); end
   endtask

   task automatic test_reset_mid();
      clear_obs();
      step(0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 16'(16'h0A00 + i), i & 1, 0, (i >> 1) & 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL midrst_en: got %b expected 0", mem_write_en); end
      checks++; if (collecting !== 1'b0) begin errors++; $display("FAIL midrst_collecting: got %b expected 0", collecting); end
      checks++; if (mem_write_addr !== '0 || mem_din !== '0) begin errors++; $display("FAIL midrst_port: got %h/%h expected 0/0", mem_write_addr, mem_din); end
      step(0, 0, 1, 16'h0BBB, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (stray !== 1'b1) begin errors++; $display("FAIL midrst_stray: got %b expected 1", stray); end
      checks++; if (act_q.size() !== 0 || mem_write_en !== 1'b0) begin errors++; $display("FAIL midrst_nowrite: got %0d words en=%b expected 0/0", act_q.size(), mem_write_en); end
   endtask

   initial begin
      rst_in = 1'b1; start = 1'b0; output_valid = 1'b0; out_s = '0;
      output_x = '0; output_y = '0; output_ch = '0; mem_write_ready = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_ordered_frame();
      test_sign_ext();
      test_stall();
      test_overflow();
      test_stray();
      test_random_frames();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
